// File: rtl/vxu_pkg.sv
// Shared definitions for the VXU issue sequencer: default widths, cfg encodings and FSM states.
package vxu_pkg;

  localparam int unsigned CNT_WIDTH_DEF     = 6;
  localparam int unsigned DATA_WIDTH_DEF    = 64;
  localparam int unsigned OPF_WIDTH_DEF     = 64;
  localparam int unsigned GAP_CYCLES_DEF    = 4;
  localparam int unsigned NTT_MAX_OUTST_DEF = 2;

  typedef enum logic [1:0] {
    CFG_EXEC  = 2'b00,
    CFG_VL    = 2'b01,
    CFG_MODQ  = 2'b10,
    CFG_MODIQ = 2'b11
  } cfg_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RUN   = 2'b10,
    ST_GAP   = 2'b11
  } state_e;

endpackage

// File: rtl/vxu_issue_seq_if.sv
// Decoded-instruction valid/ready channel feeding the VXU issue sequencer.
interface vxu_issue_seq_if
  import vxu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned OPF_WIDTH  = OPF_WIDTH_DEF
);

  logic                  vld;
  logic                  rdy;
  logic [1:0]            cfg;
  logic [CNT_WIDTH:0]    len;
  logic                  is_ntt;
  logic [DATA_WIDTH-1:0] scalar;
  logic [OPF_WIDTH-1:0]  opf;

  modport master (output vld, cfg, len, is_ntt, scalar, opf, input rdy);
  modport slave  (input vld, cfg, len, is_ntt, scalar, opf, output rdy);

endinterface

// File: rtl/vxu_issue_seq.sv
// Issue sequencer: strobes one op to the VXU, streams L element beats, then holds a drain gap.
module vxu_issue_seq
  import vxu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned OPF_WIDTH     = OPF_WIDTH_DEF,
  parameter int unsigned GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int unsigned NTT_MAX_OUTST = NTT_MAX_OUTST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  vxu_issue_seq_if.slave        inst,
  input  logic [CNT_WIDTH:0]    i_ntt_inst_std_cnt,
  output logic                  o_op_vld,
  output logic [1:0]            o_op_cfg,
  output logic [DATA_WIDTH-1:0] o_scalar_cfg,
  output logic [OPF_WIDTH-1:0]  o_op_opf,
  output logic                  o_comp_vld,
  output logic [CNT_WIDTH-1:0]  o_cnt,
  output logic                  o_busy
);

  localparam int unsigned LEN_W    = CNT_WIDTH + 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam state_e      POST_EXEC = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_e                state_q, state_d;
  cfg_e                  cfg_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [OPF_WIDTH-1:0]  opf_q;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  op_vld_q, op_vld_d;
  logic                  comp_vld_q, comp_vld_d;
  logic                  busy_q, busy_d;
  logic                  ntt_block_c;
  logic                  accept_c;

  // NTT throttle only gates the handshake; once accepted the instruction runs to completion.
  assign ntt_block_c = (cfg_e'(inst.cfg) == CFG_EXEC) && inst.is_ntt &&
                       (i_ntt_inst_std_cnt >= LEN_W'(NTT_MAX_OUTST));
  assign inst.rdy    = (state_q == ST_IDLE) && !rst && !ntt_block_c;
  assign accept_c    = inst.vld && inst.rdy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (cfg_q != CFG_EXEC)   state_d = ST_IDLE;
        else if (rem_q == '0)    state_d = POST_EXEC;
        else                     state_d = ST_RUN;
      end
      ST_RUN:   if (rem_q == LEN_W'(1)) state_d = POST_EXEC;
      ST_GAP:   if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // rem_q is the termination count; o_cnt is free to wrap when L == 2**CNT_WIDTH.
  always_comb begin
    rem_d = rem_q;
    cnt_d = '0;
    gap_d = '0;
    if (accept_c)                rem_d = inst.len;
    else if (state_q == ST_RUN)  rem_d = rem_q - LEN_W'(1);
    if ((state_d == ST_RUN) && (state_q == ST_RUN)) cnt_d = cnt_q + CNT_WIDTH'(1);
    if ((state_d == ST_GAP) && (state_q == ST_GAP)) gap_d = gap_q + GAP_W'(1);
  end

  always_comb begin
    op_vld_d   = 1'b0;
    comp_vld_d = 1'b0;
    busy_d     = 1'b0;
    op_vld_d   = (state_d == ST_ISSUE);
    comp_vld_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= CFG_EXEC;
      scalar_q   <= '0;
      opf_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      op_vld_q   <= 1'b0;
      comp_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (accept_c) begin
        cfg_q    <= cfg_e'(inst.cfg);
        scalar_q <= inst.scalar;
        opf_q    <= inst.opf;
      end
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      op_vld_q   <= op_vld_d;
      comp_vld_q <= comp_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign o_op_vld     = op_vld_q;
  assign o_op_cfg     = cfg_q;
  assign o_scalar_cfg = scalar_q;
  assign o_op_opf     = opf_q;
  assign o_comp_vld   = comp_vld_q;
  assign o_cnt        = cnt_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_vxu_issue_seq.sv
// Scoreboard bench for vxu_issue_seq: expected ops/beats queued at accept, checked as the DUT emits them.
module tb_vxu_issue_seq;

  typedef struct packed {
    logic [1:0]  cfg;
    logic [63:0] sc;
    logic [63:0] opf;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  std_cnt = '0;
  logic        op_vld, comp_vld, busy;
  logic [1:0]  op_cfg;
  logic [63:0] scalar_o, opf_o;
  logic [5:0]  cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats_seen = 0;
  op_t        op_q[$];
  logic [5:0] beat_q[$];
  int         op_cyc[$];

  vxu_issue_seq_if inst_if ();

  vxu_issue_seq dut (
    .clk                (clk),
    .rst                (rst),
    .inst               (inst_if),
    .i_ntt_inst_std_cnt (std_cnt),
    .o_op_vld           (op_vld),
    .o_op_cfg           (op_cfg),
    .o_scalar_cfg       (scalar_o),
    .o_op_opf           (opf_o),
    .o_comp_vld         (comp_vld),
    .o_cnt              (cnt),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every op strobe and beat must match the head of its queue.
  always @(negedge clk) begin
    op_t e;
    if (op_vld === 1'b1) begin
      op_cyc.push_back(cyc);
      if (op_q.size() == 0) chk("op_unexpected", {63'd0, op_vld}, 64'd0);
      else begin
        e = op_q.pop_front();
        chk("op_cfg", {62'd0, op_cfg}, {62'd0, e.cfg});
        chk("op_scalar", scalar_o, e.sc);
        chk("op_opf", opf_o, e.opf);
      end
    end
    if (comp_vld === 1'b1) begin
      beats_seen++;
      if (beat_q.size() == 0) chk("beat_unexpected", {63'd0, comp_vld}, 64'd0);
      else chk("beat_cnt", {58'd0, cnt}, {58'd0, beat_q.pop_front()});
    end
    if (op_vld === 1'b1 && comp_vld === 1'b1) chk("op_comp_overlap", 64'd1, 64'd0);
  end

  // Offer an instruction (vld left high) and return at the negedge after the accepting edge.
  task automatic offer(input logic [1:0] c, input int len, input bit ntt,
                       input logic [63:0] sc, input logic [63:0] op, output int waited);
    op_t e;
    inst_if.vld    = 1'b1;
    inst_if.cfg    = c;
    inst_if.len    = 7'(len);
    inst_if.is_ntt = ntt;
    inst_if.scalar = sc;
    inst_if.opf    = op;
    waited = 0;
    #1;
    while (inst_if.rdy !== 1'b1 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (inst_if.rdy !== 1'b1) begin
      chk("accept_timeout", {63'd0, inst_if.rdy}, 64'd1);
      inst_if.vld = 1'b0;
    end else begin
      @(posedge clk);
      e.cfg = c; e.sc = sc; e.opf = op;
      op_q.push_back(e);
      if (c == 2'b00) for (int i = 0; i < len; i++) beat_q.push_back(6'(i));
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, b0, hits;
    inst_if.vld = 1'b0; inst_if.cfg = 2'b00; inst_if.len = '0; inst_if.is_ntt = 1'b0;
    inst_if.scalar = '0; inst_if.opf = '0;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_op_vld", {63'd0, op_vld}, 64'd0);
    chk("rst_comp_vld", {63'd0, comp_vld}, 64'd0);
    chk("rst_cnt", {58'd0, cnt}, 64'd0);
    chk("rst_op_cfg", {62'd0, op_cfg}, 64'd0);
    chk("rst_scalar", scalar_o, 64'd0);
    chk("rst_opf", opf_o, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rdy", {63'd0, inst_if.rdy}, 64'd1);
    @(negedge clk);

    // set vl: op strobe only, no beats
    b0 = beats_seen;
    offer(2'b01, 0, 1'b0, 64'd4096, 64'h1111_2222_3333_4444, w);
    chk("cfg_wait", 64'(w), 64'd0);
    chk("cfg_op_vld", {63'd0, op_vld}, 64'd1);
    inst_if.vld = 1'b0;
    wait_idle(20);
    chk("cfg_no_beats", 64'(beats_seen - b0), 64'd0);

    // exec L=4: exact cycle timing relative to accept
    offer(2'b00, 4, 1'b0, 64'h0, 64'hA5A5_0000_0000_0004, w);
    inst_if.vld = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("t%0d_op_vld", k), {63'd0, op_vld}, (k == 1) ? 64'd1 : 64'd0);
      chk($sformatf("t%0d_comp_vld", k), {63'd0, comp_vld}, (k >= 2 && k <= 5) ? 64'd1 : 64'd0);
      chk($sformatf("t%0d_rdy", k), {63'd0, inst_if.rdy}, (k == 10) ? 64'd1 : 64'd0);
      if (k < 10) @(negedge clk);
    end
    chk("l4_cnt_idle", {58'd0, cnt}, 64'd0);
    @(negedge clk);

    // exec L=64 (full wrap) and L=0
    b0 = beats_seen;
    offer(2'b00, 64, 1'b0, 64'h0, 64'hBEEF_0040, w);
    inst_if.vld = 1'b0;
    wait_idle(200);
    chk("l64_beats", 64'(beats_seen - b0), 64'd64);
    chk("l64_queue", 64'(beat_q.size()), 64'd0);
    b0 = beats_seen;
    offer(2'b00, 0, 1'b0, 64'h0, 64'hBEEF_0000, w);
    inst_if.vld = 1'b0;
    wait_idle(20);
    chk("l0_beats", 64'(beats_seen - b0), 64'd0);
    chk("l0_ops_left", 64'(op_q.size()), 64'd0);

    // NTT throttle
    std_cnt = 7'd2;
    inst_if.vld = 1'b1; inst_if.cfg = 2'b00; inst_if.len = 7'd2; inst_if.is_ntt = 1'b1;
    inst_if.scalar = 64'h0; inst_if.opf = 64'hCAFE_0002;
    hits = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (inst_if.rdy === 1'b1) hits++;
    end
    chk("ntt_hold", 64'(hits), 64'd0);
    chk("ntt_hold_busy", {63'd0, busy}, 64'd0);
    std_cnt = 7'd1;
    offer(2'b00, 2, 1'b1, 64'h0, 64'hCAFE_0002, w);
    chk("ntt_release_wait", 64'(w), 64'd0);
    inst_if.vld = 1'b0;
    std_cnt = 7'd2;
    wait_idle(30);
    offer(2'b00, 3, 1'b0, 64'h0, 64'hCAFE_0003, w);
    chk("non_ntt_wait", 64'(w), 64'd0);
    inst_if.vld = 1'b0;
    wait_idle(30);
    std_cnt = 7'd0;

    // reset during RUN at beat 5 of L=32
    offer(2'b00, 32, 1'b0, 64'h0, 64'hDEAD_0020, w);
    inst_if.vld = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_comp_vld", {63'd0, comp_vld}, 64'd0);
    chk("abort_op_vld", {63'd0, op_vld}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_cnt", {58'd0, cnt}, 64'd0);
    chk("abort_rdy", {63'd0, inst_if.rdy}, 64'd1);
    chk("abort_beats_left", 64'(beat_q.size()), 64'd26);
    beat_q.delete();
    @(negedge clk);
    offer(2'b10, 0, 1'b0, 64'h0000_0000_0001_E001, 64'h77, w);
    chk("post_abort_wait", 64'(w), 64'd0);
    inst_if.vld = 1'b0;
    wait_idle(20);

    // back-to-back cfg with vld held
    op_cyc.delete();
    offer(2'b01, 0, 1'b0, 64'd128, 64'h1, w);
    offer(2'b10, 0, 1'b0, 64'h0000_0000_0C00_0001, 64'h2, w);
    offer(2'b11, 0, 1'b0, 64'hFFFF_0000_1234_5678, 64'h3, w);
    inst_if.vld = 1'b0;
    wait_idle(20);
    chk("b2b_ops", 64'(op_cyc.size()), 64'd3);
    if (op_cyc.size() == 3) begin
      chk("b2b_gap01", 64'(op_cyc[1] - op_cyc[0]), 64'd2);
      chk("b2b_gap12", 64'(op_cyc[2] - op_cyc[1]), 64'd2);
    end

    repeat (5) @(negedge clk);
    chk("final_ops_left", 64'(op_q.size()), 64'd0);
    chk("final_beats_left", 64'(beat_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
